// File: rtl/count_pwm_gen_if.sv
// Duty-request / PWM-status bundle between the upstream counter, count_pwm_gen and its control logic.
interface count_pwm_gen_if #(
  parameter int WIDTH = 4
);
  logic             en;
  logic [WIDTH-1:0] count_in;
  logic             pwm_out;
  logic             period_start;
  logic [WIDTH-1:0] duty_q;
  logic             sat_hi;
  logic             sat_lo;

  modport master (
    output en, count_in,
    input  pwm_out, period_start, duty_q, sat_hi, sat_lo
  );

  modport slave (
    input  en, count_in,
    output pwm_out, period_start, duty_q, sat_hi, sat_lo
  );
endinterface

// File: rtl/count_pwm_gen.sv
// Glitch-free PWM from a saturating counter value; duty is latched only at period boundaries.
module count_pwm_gen #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  count_pwm_gen_if.slave   bus
);
  localparam logic [7:0]       PRE_MAX   = 8'(PRESCALE - 1);
  localparam logic [WIDTH-1:0] PHASE_MAX = WIDTH'(2**WIDTH - 2);
  localparam logic [WIDTH-1:0] DUTY_MAX  = WIDTH'(2**WIDTH - 1);

  logic [7:0]       pre_q, pre_d;
  logic [WIDTH-1:0] phase_q, phase_d;
  logic [WIDTH-1:0] duty_q;
  logic             pwm_q, ps_q;
  logic             load;
  logic [WIDTH-1:0] eff;

  // Phase stops one short of all-ones so a full-scale duty keeps the output high.
  always_comb begin
    load    = (pre_q == 8'd0) && (phase_q == '0);
    eff     = load ? bus.count_in : duty_q;
    pre_d   = (pre_q == PRE_MAX) ? 8'd0 : pre_q + 8'd1;
    phase_d = phase_q;
    if (pre_q == PRE_MAX)
      phase_d = (phase_q == PHASE_MAX) ? '0 : phase_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_q   <= 8'd0;
      phase_q <= '0;
      duty_q  <= '0;
      pwm_q   <= 1'b0;
      ps_q    <= 1'b0;
    end else if (bus.en) begin
      pre_q   <= pre_d;
      phase_q <= phase_d;
      duty_q  <= eff;
      pwm_q   <= (phase_q < eff);
      ps_q    <= load;
    end else begin
      pwm_q   <= 1'b0;
      ps_q    <= 1'b0;
    end
  end

  assign bus.pwm_out      = pwm_q;
  assign bus.period_start = ps_q;
  assign bus.duty_q       = duty_q;
  assign bus.sat_hi       = (duty_q == DUTY_MAX);
  assign bus.sat_lo       = (duty_q == '0);
endmodule

// File: tb/tb_count_pwm_gen.sv
// Directed checks of count_pwm_gen at PRESCALE=1 (instance a) and PRESCALE=3 (instance b).
module tb_count_pwm_gen;
  logic clk;
  logic rst_a, rst_b;
  int   n_cmp, n_bad;

  count_pwm_gen_if #(.WIDTH(4)) ifa ();
  count_pwm_gen_if #(.WIDTH(4)) ifb ();

  count_pwm_gen #(.WIDTH(4), .PRESCALE(1)) dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa));
  count_pwm_gen #(.WIDTH(4), .PRESCALE(3)) dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       rst_n;
    logic       en;
    logic [3:0] cnt;
    logic       pwm;
    logic       ps;
    logic [3:0] duty;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic [3:0] c,
                     input logic p, input logic s, input logic [3:0] d);
    vec_t v;
    v.rst_n = r; v.en = e; v.cnt = c; v.pwm = p; v.ps = s; v.duty = d;
    tbl.push_back(v);
  endtask

  task automatic drv(input int inst, input logic r, input logic e, input logic [3:0] c);
    if (inst == 0) begin rst_a = r; ifa.en = e; ifa.count_in = c; end
    else           begin rst_b = r; ifb.en = e; ifb.count_in = c; end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int inst, input logic p, input logic s,
                     input logic [3:0] d);
    logic [7:0] act, exp;
    if (inst == 0)
      act = {ifa.pwm_out, ifa.period_start, ifa.duty_q, ifa.sat_hi, ifa.sat_lo};
    else
      act = {ifb.pwm_out, ifb.period_start, ifb.duty_q, ifb.sat_hi, ifb.sat_lo};
    exp = {p, s, d, (d == 4'd15), (d == 4'd0)};
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got {pwm,ps,duty,hi,lo}=%b expected %b", nm, $time, act, exp);
    end
  endtask

  // One full enabled period starting at a load cycle.
  task automatic run_period(input string nm, input int inst, input logic [3:0] cnt,
                            input int d, input int pres);
    for (int k = 0; k < pres * 15; k++) begin
      drv(inst, 1'b1, 1'b1, cnt);
      tick();
      chk(nm, inst, k < pres * d, k == 0, 4'(d));
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    drv(1, 1'b0, 1'b0, 4'd0);

    // Reset held with en=1, then duty 5 for one period plus the next load.
    for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 4'd9, 1'b0, 1'b0, 4'd0);
    add(1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 4'd5);
    for (int i = 0; i < 4;  i++) add(1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 4'd5);
    for (int i = 0; i < 10; i++) add(1'b1, 1'b1, 4'd5, 1'b0, 1'b0, 4'd5);
    add(1'b1, 1'b1, 4'd5, 1'b1, 1'b1, 4'd5);

    foreach (tbl[i]) begin
      drv(0, tbl[i].rst_n, tbl[i].en, tbl[i].cnt);
      tick();
      chk($sformatf("vec%0d", i), 0, tbl[i].pwm, tbl[i].ps, tbl[i].duty);
    end

    // Mid-period change to 12 at phase 7 must not disturb the running period.
    for (int k = 1; k < 7; k++) begin
      drv(0, 1'b1, 1'b1, 4'd5); tick(); chk("mid_pre", 0, k < 5, 1'b0, 4'd5);
    end
    for (int k = 7; k < 15; k++) begin
      drv(0, 1'b1, 1'b1, 4'd12); tick(); chk("mid_post", 0, 1'b0, 1'b0, 4'd5);
    end
    run_period("duty12", 0, 4'd12, 12, 1);

    for (int p = 0; p < 3; p++) run_period("duty15", 0, 4'd15, 15, 1);
    run_period("duty0", 0, 4'd0, 0, 1);

    // Enable pause at phase 3 of a duty-8 period stretches it by 4 cycles.
    for (int k = 0; k < 3; k++) begin
      drv(0, 1'b1, 1'b1, 4'd8); tick(); chk("pause_a", 0, 1'b1, k == 0, 4'd8);
    end
    for (int k = 0; k < 4; k++) begin
      drv(0, 1'b1, 1'b0, 4'd8); tick(); chk("pause_off", 0, 1'b0, 1'b0, 4'd8);
    end
    for (int k = 3; k < 15; k++) begin
      drv(0, 1'b1, 1'b1, 4'd8); tick(); chk("pause_b", 0, k < 8, 1'b0, 4'd8);
    end
    drv(0, 1'b1, 1'b1, 4'd8); tick(); chk("pause_reload", 0, 1'b1, 1'b1, 4'd8);
    drv(0, 1'b1, 1'b1, 4'd8); tick(); chk("pause_ph1", 0, 1'b1, 1'b0, 4'd8);

    // Reset while the output is high.
    drv(0, 1'b0, 1'b1, 4'd8); tick(); chk("rst_hi", 0, 1'b0, 1'b0, 4'd0);
    drv(0, 1'b1, 1'b1, 4'd3); tick(); chk("rst_rel", 0, 1'b1, 1'b1, 4'd3);
    drv(0, 1'b0, 1'b0, 4'd0);

    // PRESCALE=3, duty 4: 45-cycle period, 12 high.
    run_period("p3_a", 1, 4'd4, 4, 3);
    run_period("p3_b", 1, 4'd4, 4, 3);
    for (int k = 0; k < 20; k++) begin
      drv(1, 1'b1, 1'b1, 4'd4); tick(); chk("p3_part", 1, k < 12, k == 0, 4'd4);
    end
    drv(1, 1'b0, 1'b1, 4'd4); tick(); chk("p3_rst", 1, 1'b0, 1'b0, 4'd0);
    run_period("p3_fresh", 1, 4'd4, 4, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
